ifetch_axi_bridge: RTL and testbench

IFETCH_AXI_BRIDGE -- requirements
Module: ifetch_axi_bridge

---
 rtl/ifetch_axi_bridge.sv | 207 ++++++++++++++++++++
 tb/tb_ifetch_axi_bridge.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_axi_bridge.sv
// rtl/ifetch_axi_bridge.sv - single-beat AXI read bridge for the instruction fetch stage
//
// Ports:
//   cpu_clk, cpu_rst          clock; synchronous active-high reset
//   inst_req, inst_addr       fetch request and word address from the IF stage
//   flush                     redirect/exception, cancels the fetch in flight
//   inst_rdata, inst_valid    fetched word and its one-cycle delivery strobe
//   inst_err                  qualifies inst_valid: 1 = non-OKAY read response
//   stallreq_rinst            holds the pipeline while a fetch is outstanding
//   arid..arvalid, arready    AXI read address channel (single beat, id 0, INCR, 4 bytes)
//   rid..rvalid, rready       AXI read data channel
//
// Build option IFETCH_BUF_EN: one-entry fetch buffer (tag, data, valid) that answers a
// repeat fetch of the last good address without an AXI transaction.

module ifetch_axi_bridge (
   input  logic        cpu_clk,
   input  logic        cpu_rst,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   input  logic        flush,
   output logic [31:0] inst_rdata,
   output logic        inst_valid,
   output logic        inst_err,
   output logic        stallreq_rinst,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      AR   = 2'd1,
      R    = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        discard_q, discard_d;
   logic        arvalid_q, arvalid_d;
   logic        rready_q, rready_d;
   logic        inst_valid_q, inst_valid_d;
   logic        inst_err_q, inst_err_d;
   logic [31:0] inst_rdata_q, inst_rdata_d;
   logic [31:0] araddr_q, araddr_d;

   logic        beat_done;
   logic        beat_keep;
   logic        buf_hit;
   logic [31:0] buf_rdata;
   logic        unused_rid;

   assign arid    = 4'd0;
   assign arlen   = 8'd0;
   assign arsize  = 3'b010;
   assign arburst = 2'b01;

   assign araddr     = araddr_q;
   assign arvalid    = arvalid_q;
   assign rready     = rready_q;
   assign inst_rdata = inst_rdata_q;
   assign inst_err   = inst_err_q;

   // A flush arriving in the delivery cycle suppresses the strobe combinationally.
   assign inst_valid = inst_valid_q & ~flush;

   assign stallreq_rinst = ~cpu_rst & ((state_q == AR) | (state_q == R) |
                                       ((state_q == IDLE) & inst_req));

   // Last (only) beat of the read; kept unless flushed earlier or in this same cycle.
   assign beat_done = (state_q == R) & rvalid & rlast;
   assign beat_keep = beat_done & ~discard_q & ~flush;

   // The bridge only ever issues id 0, so the returned id carries no information.
   assign unused_rid = ^rid;

`ifdef IFETCH_BUF_EN
   logic        buf_valid_q, buf_valid_d;
   logic [31:0] buf_tag_q, buf_tag_d;
   logic [31:0] buf_data_q, buf_data_d;

   assign buf_hit   = buf_valid_q & (inst_addr == buf_tag_q);
   assign buf_rdata = buf_data_q;

   always_comb begin
      buf_valid_d = buf_valid_q;
      buf_tag_d   = buf_tag_q;
      buf_data_d  = buf_data_q;
      // Only a delivered OKAY word is worth remembering.
      if (beat_keep && (rresp == 2'b00)) begin
         buf_valid_d = 1'b1;
         buf_tag_d   = araddr_q;
         buf_data_d  = rdata;
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         buf_valid_q <= 1'b0;
         buf_tag_q   <= 32'd0;
         buf_data_q  <= 32'd0;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_tag_q   <= buf_tag_d;
         buf_data_q  <= buf_data_d;
      end
   end
`else
   assign buf_hit   = 1'b0;
   assign buf_rdata = 32'd0;
`endif

   always_comb begin
      state_d      = state_q;
      discard_d    = discard_q;
      arvalid_d    = arvalid_q;
      rready_d     = rready_q;
      inst_valid_d = 1'b0;
      inst_err_d   = inst_err_q;
      inst_rdata_d = inst_rdata_q;
      araddr_d     = araddr_q;

      case (state_q)
         IDLE: begin
            if (inst_req) begin
               if (buf_hit) begin
                  inst_rdata_d = buf_rdata;
                  inst_err_d   = 1'b0;
                  inst_valid_d = 1'b1;
                  state_d      = DONE;
               end else begin
                  araddr_d  = inst_addr;
                  arvalid_d = 1'b1;
                  state_d   = AR;
               end
            end
         end
         AR: begin
            if (flush) begin
               discard_d = 1'b1;
            end
            if (arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = R;
            end
         end
         R: begin
            if (flush) begin
               discard_d = 1'b1;
            end
            if (beat_done) begin
               rready_d = 1'b0;
               if (beat_keep) begin
                  inst_rdata_d = rdata;
                  inst_err_d   = (rresp != 2'b00);
                  inst_valid_d = 1'b1;
                  state_d      = DONE;
               end else begin
                  // Transaction has drained on AXI; drop the word silently.
                  discard_d = 1'b0;
                  state_d   = IDLE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         state_q      <= IDLE;
         discard_q    <= 1'b0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         inst_valid_q <= 1'b0;
         inst_err_q   <= 1'b0;
         inst_rdata_q <= 32'd0;
         araddr_q     <= 32'd0;
      end else begin
         state_q      <= state_d;
         discard_q    <= discard_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
         inst_valid_q <= inst_valid_d;
         inst_err_q   <= inst_err_d;
         inst_rdata_q <= inst_rdata_d;
         araddr_q     <= araddr_d;
      end
   end

endmodule

// File: tb/tb_ifetch_axi_bridge.sv
// tb/tb_ifetch_axi_bridge.sv - scoreboard bench for ifetch_axi_bridge

module tb_ifetch_axi_bridge;

   logic        cpu_clk;
   logic        cpu_rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        flush;
   logic [31:0] inst_rdata;
   logic        inst_valid;
   logic        inst_err;
   logic        stallreq_rinst;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   ifetch_axi_bridge dut (
      .cpu_clk        (cpu_clk),
      .cpu_rst        (cpu_rst),
      .inst_req       (inst_req),
      .inst_addr      (inst_addr),
      .flush          (flush),
      .inst_rdata     (inst_rdata),
      .inst_valid     (inst_valid),
      .inst_err       (inst_err),
      .stallreq_rinst (stallreq_rinst),
      .arid           (arid),
      .araddr         (araddr),
      .arlen          (arlen),
      .arsize         (arsize),
      .arburst        (arburst),
      .arvalid        (arvalid),
      .arready        (arready),
      .rid            (rid),
      .rdata          (rdata),
      .rresp          (rresp),
      .rlast          (rlast),
      .rvalid         (rvalid),
      .rready         (rready)
   );

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          at_cyc;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        e;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] last_data = 32'd0;

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   always @(posedge cpu_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every delivery strobe must match the head of the scoreboard.
   always @(negedge cpu_clk) begin
      if (!cpu_rst) begin
         if (exp_q.size() > 0 && cyc > exp_q[0].at_cyc) begin
            chk("missing_inst_valid", 32'd0, 32'd1);
            void'(exp_q.pop_front());
         end
         if (inst_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_inst_valid", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("inst_rdata", inst_rdata, e.data);
               chk("inst_err", {31'd0, inst_err}, {31'd0, e.err});
               chk("inst_valid_cycle", cyc, e.at_cyc);
            end
         end
      end
   end

   // fl_mode: 0 none, 1 flush during the IDLE request cycle, 2 flush during DONE.
   task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] resp, input int ar_wait, input int r_wait,
                        input int fl_mode);
      exp_t x;
      int   c0;
      @(posedge cpu_clk); #1;
      c0        = cyc;
      inst_req  = 1'b1;
      inst_addr = addr;
      flush     = (fl_mode == 1);
      if (fl_mode != 2) begin
         x.data   = data;
         x.err    = (resp != 2'b00);
         x.at_cyc = c0 + 3 + ar_wait + r_wait;
         exp_q.push_back(x);
      end
      @(negedge cpu_clk);
      chk("stall_req_cycle", {31'd0, stallreq_rinst}, 32'd1);
      chk("arvalid_req_cycle", {31'd0, arvalid}, 32'd0);
      for (int i = 0; i <= ar_wait; i++) begin
         @(posedge cpu_clk); #1;
         flush   = 1'b0;
         arready = (i == ar_wait);
         @(negedge cpu_clk);
         chk("arvalid_ar", {31'd0, arvalid}, 32'd1);
         chk("araddr_ar", araddr, addr);
         chk("stall_ar", {31'd0, stallreq_rinst}, 32'd1);
      end
      for (int j = 0; j <= r_wait; j++) begin
         @(posedge cpu_clk); #1;
         arready = 1'b0;
         rvalid  = (j == r_wait);
         rlast   = (j == r_wait);
         rdata   = (j == r_wait) ? data : 32'h5A5A5A5A;
         rresp   = resp;
         @(negedge cpu_clk);
         chk("rready_r", {31'd0, rready}, 32'd1);
         chk("arvalid_r", {31'd0, arvalid}, 32'd0);
         chk("stall_r", {31'd0, stallreq_rinst}, 32'd1);
      end
      @(posedge cpu_clk); #1;
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
      flush  = (fl_mode == 2);
      @(negedge cpu_clk);
      chk("stall_done", {31'd0, stallreq_rinst}, 32'd0);
      if (fl_mode == 2) begin
         chk("inst_valid_flushed", {31'd0, inst_valid}, 32'd0);
      end
      @(posedge cpu_clk); #1;
      inst_req = 1'b0;
      flush    = 1'b0;
      last_data = data;
      @(negedge cpu_clk);
      chk("inst_rdata_hold", inst_rdata, data);
   endtask

   // Fetch whose beat is discarded: flush at R cycle offset fl_at, rlast at offset r_at.
   task automatic fetch_discard(input logic [31:0] addr, input int fl_at, input int r_at);
      @(posedge cpu_clk); #1;
      inst_req  = 1'b1;
      inst_addr = addr;
      arready   = 1'b1;
      @(posedge cpu_clk); #1;
      @(negedge cpu_clk);
      chk("arvalid_disc", {31'd0, arvalid}, 32'd1);
      for (int k = 0; k <= r_at; k++) begin
         @(posedge cpu_clk); #1;
         arready = 1'b0;
         flush   = (k == fl_at);
         rvalid  = (k == r_at);
         rlast   = (k == r_at);
         rdata   = 32'hDEADBEEF;
         @(negedge cpu_clk);
         chk("rready_disc", {31'd0, rready}, 32'd1);
         chk("stall_disc", {31'd0, stallreq_rinst}, 32'd1);
      end
      @(posedge cpu_clk); #1;
      flush    = 1'b0;
      rvalid   = 1'b0;
      rlast    = 1'b0;
      inst_req = 1'b0;
      @(negedge cpu_clk);
      chk("stall_after_disc", {31'd0, stallreq_rinst}, 32'd0);
      chk("arvalid_after_disc", {31'd0, arvalid}, 32'd0);
      chk("rready_after_disc", {31'd0, rready}, 32'd0);
      chk("inst_rdata_kept", inst_rdata, last_data);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cpu_rst   = 1'b1;
      inst_req  = 1'b1;
      inst_addr = 32'hBFC00000;
      flush     = 1'b0;
      arready   = 1'b0;
      rid       = 4'd0;
      rdata     = 32'd0;
      rresp     = 2'b00;
      rlast     = 1'b0;
      rvalid    = 1'b0;
      repeat (3) @(posedge cpu_clk);
      @(negedge cpu_clk);
      chk("rst_stall", {31'd0, stallreq_rinst}, 32'd0);
      chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
      chk("rst_rready", {31'd0, rready}, 32'd0);
      chk("rst_inst_rdata", inst_rdata, 32'd0);
      chk("rst_inst_err", {31'd0, inst_err}, 32'd0);
      chk("rst_araddr", araddr, 32'd0);
      chk("arid", {28'd0, arid}, 32'd0);
      chk("arlen", {24'd0, arlen}, 32'd0);
      chk("arsize", {29'd0, arsize}, 32'd2);
      chk("arburst", {30'd0, arburst}, 32'd1);
      @(posedge cpu_clk); #1;
      cpu_rst  = 1'b0;
      inst_req = 1'b0;

      fetch(32'hBFC00000, 32'h3C088000, 2'b00, 0, 0, 0);
      fetch(32'hBFC00010, 32'h24090001, 2'b00, 5, 0, 0);
      fetch(32'hBFC00020, 32'h8D2A0000, 2'b00, 2, 3, 1);

      fetch_discard(32'hBFC00100, 0, 2);
      fetch(32'hBFC00380, 32'h01234567, 2'b00, 0, 0, 0);
      fetch(32'hBFC00100, 32'hAABBCCDD, 2'b00, 0, 1, 0);
      fetch_discard(32'hBFC00140, 0, 0);

      fetch(32'hBFC00200, 32'h00000000, 2'b10, 0, 0, 0);
      fetch(32'hBFC00200, 32'h11112222, 2'b00, 1, 0, 0);
      fetch(32'hBFC00300, 32'hCAFEF00D, 2'b00, 0, 0, 2);

`ifdef IFETCH_BUF_EN
      begin
         exp_t x;
         fetch(32'hBFC00004, 32'h00851021, 2'b00, 0, 0, 0);
         @(posedge cpu_clk); #1;
         inst_req  = 1'b1;
         inst_addr = 32'hBFC00004;
         x.data    = 32'h00851021;
         x.err     = 1'b0;
         x.at_cyc  = cyc + 1;
         exp_q.push_back(x);
         @(negedge cpu_clk);
         chk("hit_stall_req", {31'd0, stallreq_rinst}, 32'd1);
         chk("hit_arvalid_req", {31'd0, arvalid}, 32'd0);
         @(posedge cpu_clk); #1;
         @(negedge cpu_clk);
         chk("hit_arvalid_done", {31'd0, arvalid}, 32'd0);
         chk("hit_stall_done", {31'd0, stallreq_rinst}, 32'd0);
         @(posedge cpu_clk); #1;
         inst_req = 1'b0;
      end
`endif

      // Reset while waiting in R.
      @(posedge cpu_clk); #1;
      inst_req  = 1'b1;
      inst_addr = 32'hBFC00400;
      arready   = 1'b1;
      @(posedge cpu_clk); #1;
      @(posedge cpu_clk); #1;
      arready = 1'b0;
      @(negedge cpu_clk);
      chk("pre_rst_rready", {31'd0, rready}, 32'd1);
      @(posedge cpu_clk); #1;
      cpu_rst = 1'b1;
      @(negedge cpu_clk);
      chk("in_rst_stall", {31'd0, stallreq_rinst}, 32'd0);
      @(posedge cpu_clk); #1;
      cpu_rst  = 1'b0;
      inst_req = 1'b0;
      @(negedge cpu_clk);
      chk("post_rst_arvalid", {31'd0, arvalid}, 32'd0);
      chk("post_rst_rready", {31'd0, rready}, 32'd0);
      chk("post_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("post_rst_stall", {31'd0, stallreq_rinst}, 32'd0);
      chk("post_rst_inst_rdata", inst_rdata, 32'd0);
      last_data = 32'd0;

      fetch(32'hBFC00004, 32'h00851021, 2'b00, 0, 0, 0);

      repeat (4) @(posedge cpu_clk);
      @(negedge cpu_clk);
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
